// File: rtl/depth_writer_pkg.sv
// Shared renderer types plus the pixel record and framebuffer address width
// used by the depth-test/write stage.
package depth_writer_pkg;
  localparam int WIDTH     = 320;
  localparam int HEIGHT    = 240;
  localparam int FB_ADDR_W = $clog2(WIDTH * HEIGHT);

  typedef logic signed [31:0] q16_16_t;
  typedef logic [11:0]        color12_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    q16_16_t     depth;
    color12_t    color;
    logic        compare_depth;
  } pixel_t;

  // Pipeline payload once the pixel has been turned into an address.
  typedef struct packed {
    q16_16_t  depth;
    color12_t color;
    logic     compare_depth;
  } stage_t;
endpackage

// File: rtl/depth_writer_if.sv
// Pixel stream, depth BRAM port and framebuffer write port of depth_writer.
// master = surrounding system, slave = depth_writer.
interface depth_writer_if
  import depth_writer_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);
  pixel_t            in_pixel;
  logic              in_valid;
  logic              in_ready;
  logic              depth_rd_en;
  logic [ADDR_W-1:0] depth_rd_addr;
  q16_16_t           depth_rd_data;
  logic              depth_wr_en;
  logic [ADDR_W-1:0] depth_wr_addr;
  q16_16_t           depth_wr_data;
  logic              fb_valid;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  color12_t          fb_color;

  modport master (
    output in_pixel, in_valid, depth_rd_data, fb_ready,
    input  in_ready, depth_rd_en, depth_rd_addr, depth_wr_en, depth_wr_addr,
           depth_wr_data, fb_valid, fb_addr, fb_color
  );

  modport slave (
    input  in_pixel, in_valid, depth_rd_data, fb_ready,
    output in_ready, depth_rd_en, depth_rd_addr, depth_wr_en, depth_wr_addr,
           depth_wr_data, fb_valid, fb_addr, fb_color
  );
endinterface

// File: rtl/depth_writer_pixel_addr_gen.sv
// Linear framebuffer address y*WIDTH + x and on-screen check; shared with scanout.
module pixel_addr_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic [15:0]       x_i,
  input  logic [15:0]       y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);
  // Address is meaningless when out of range; callers gate on in_range_o.
  assign addr_o     = ADDR_W'(y_i) * ADDR_W'(WIDTH) + ADDR_W'(x_i);
  assign in_range_o = (32'(x_i) < 32'(WIDTH)) && (32'(y_i) < 32'(HEIGHT));
endmodule

// File: rtl/depth_writer.sv
// Two-stage depth read-compare-write pipeline with read-after-write forwarding;
// S1 compares against the BRAM read, S2 holds the winner for the framebuffer.
module depth_writer
  import depth_writer_pkg::*;
#(
  parameter int WIDTH  = depth_writer_pkg::WIDTH,
  parameter int HEIGHT = depth_writer_pkg::HEIGHT,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           begin_frame_i,
  depth_writer_if.slave  bus,
  output logic [31:0]    pixels_written_o,
  output logic [31:0]    pixels_rejected_o,
  output logic           busy_o
);
  logic [ADDR_W-1:0] in_addr;
  logic              in_range;

  pixel_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_addr (
    .x_i       (bus.in_pixel.x),
    .y_i       (bus.in_pixel.y),
    .addr_o    (in_addr),
    .in_range_o(in_range)
  );

  logic [2:1]        vld_pipe_q;
  stage_t            s1_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q, lw_addr_q;
  logic              s1_fresh_q, lw_vld_q;
  q16_16_t           s1_rdata_q, s2_depth_q, lw_depth_q;
  color12_t          s2_color_q;
  logic [31:0]       wr_cnt_q, wr_cnt_d, rej_cnt_q, rej_cnt_d;

  logic    accept, s1_adv, fb_fire, win;
  q16_16_t mem_depth, stored;
  logic [1:0] rej_inc;

  assign fb_fire      = vld_pipe_q[2] & bus.fb_ready;
  assign s1_adv       = vld_pipe_q[1] & (~vld_pipe_q[2] | bus.fb_ready);
  assign bus.in_ready = ~vld_pipe_q[1] | s1_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.depth_rd_en   = accept & in_range;
  assign bus.depth_rd_addr = in_addr;

  // Read data is only on the port the cycle after the read; hold it if stalled.
  assign mem_depth = s1_fresh_q ? bus.depth_rd_data : s1_rdata_q;

  // Newest value wins: S2 (not yet written), then last write, then memory.
  always_comb begin
    stored = mem_depth;
    if (lw_vld_q && lw_addr_q == s1_addr_q)       stored = lw_depth_q;
    if (vld_pipe_q[2] && s2_addr_q == s1_addr_q)  stored = s2_depth_q;
  end

  assign win     = ~s1_q.compare_depth | ($signed(s1_q.depth) < $signed(stored));
  assign rej_inc = {1'b0, accept & ~in_range} + {1'b0, s1_adv & ~win};

  always_comb begin
    wr_cnt_d  = (begin_frame_i ? 32'd0 : wr_cnt_q) + {31'd0, fb_fire};
    rej_cnt_d = (begin_frame_i ? 32'd0 : rej_cnt_q) + {30'd0, rej_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s1_addr_q  <= '0;
      s1_fresh_q <= 1'b0;
      s1_rdata_q <= '0;
      s2_addr_q  <= '0;
      s2_depth_q <= '0;
      s2_color_q <= '0;
      lw_vld_q   <= 1'b0;
      lw_addr_q  <= '0;
      lw_depth_q <= '0;
      wr_cnt_q   <= '0;
      rej_cnt_q  <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
      s1_fresh_q <= 1'b0;
      if (s1_fresh_q) s1_rdata_q <= bus.depth_rd_data;

      if (bus.depth_rd_en) begin
        vld_pipe_q[1] <= 1'b1;
        s1_fresh_q    <= 1'b1;
        s1_addr_q     <= in_addr;
        s1_q          <= '{depth: bus.in_pixel.depth, color: bus.in_pixel.color,
                           compare_depth: bus.in_pixel.compare_depth};
      end else if (s1_adv) begin
        vld_pipe_q[1] <= 1'b0;
      end

      if (s1_adv && win) begin
        vld_pipe_q[2] <= 1'b1;
        s2_addr_q     <= s1_addr_q;
        s2_depth_q    <= s1_q.depth;
        s2_color_q    <= s1_q.color;
      end else if (fb_fire) begin
        vld_pipe_q[2] <= 1'b0;
      end

      if (fb_fire) begin
        lw_vld_q   <= 1'b1;
        lw_addr_q  <= s2_addr_q;
        lw_depth_q <= s2_depth_q;
      end
    end
  end

  assign bus.fb_valid      = vld_pipe_q[2];
  assign bus.fb_addr       = s2_addr_q;
  assign bus.fb_color      = s2_color_q;
  assign bus.depth_wr_en   = fb_fire;
  assign bus.depth_wr_addr = s2_addr_q;
  assign bus.depth_wr_data = s2_depth_q;

  assign pixels_written_o  = wr_cnt_q;
  assign pixels_rejected_o = rej_cnt_q;
  assign busy_o            = |vld_pipe_q;
endmodule

// File: tb/tb_depth_writer.sv
// Randomized + directed bench for depth_writer: a sequential z-buffer model
// predicts framebuffer writes into a scoreboard that a monitor drains.
module tb_depth_writer;
  import depth_writer_pkg::*;

  localparam int NPIX = WIDTH * HEIGHT;

  typedef struct {
    int addr;
    int color;
    int depth;
    int acc;
    bit lat;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        begin_frame = 0;
  logic [31:0] pixels_written, pixels_rejected;
  logic        busy;

  depth_writer_if dif();

  depth_writer dut (
    .clk              (clk),
    .rst              (rst),
    .begin_frame_i    (begin_frame),
    .bus              (dif.slave),
    .pixels_written_o (pixels_written),
    .pixels_rejected_o(pixels_rejected),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int   mem   [0:NPIX-1];
  int   ref_d [0:NPIX-1];
  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   exp_wr = 0, exp_rej = 0;
  bit   fbr_rand = 0;
  bit   stall_prev = 0;
  int   prev_addr = 0, prev_color = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // External read-first depth BRAM.
  always @(posedge clk) begin
    int rd;
    rd = 0;
    if (dif.depth_rd_en) rd = mem[dif.depth_rd_addr];
    if (dif.depth_wr_en) mem[dif.depth_wr_addr] = dif.depth_wr_data;
    if (dif.depth_rd_en) dif.depth_rd_data <= rd;
  end

  always @(negedge clk) if (fbr_rand) dif.fb_ready = ($urandom_range(0, 3) != 0);

  task automatic chk(input string n, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, expv);
    end
  endtask

  // Monitor: framebuffer writes against the scoreboard, write-port discipline.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      chk("wr_en_only_on_handshake", longint'(dif.depth_wr_en),
          longint'(dif.fb_valid && dif.fb_ready));
      if (dif.fb_valid && stall_prev) begin
        chk("fb_addr_stable", dif.fb_addr, prev_addr);
        chk("fb_color_stable", dif.fb_color, prev_color);
      end
      if (dif.fb_valid && dif.fb_ready) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_fb_write addr=%0d", dif.fb_addr);
        end else begin
          e = sb.pop_front();
          chk("fb_addr", dif.fb_addr, e.addr);
          chk("fb_color", dif.fb_color, e.color);
          chk("depth_wr_addr", dif.depth_wr_addr, e.addr);
          chk("depth_wr_data", dif.depth_wr_data, e.depth);
          if (e.lat) chk("latency", cyc, e.acc + 2);
        end
      end
      stall_prev = dif.fb_valid && !dif.fb_ready;
      prev_addr  = int'(dif.fb_addr);
      prev_color = int'(dif.fb_color);
    end else begin
      stall_prev = 0;
    end
  end

  // Present one pixel until accepted; the model decides its fate at accept.
  task automatic send(input int x, input int y, input int d, input int c,
                      input bit cmp, input bit lat);
    bit ok, rng;
    int a;
    ok = 0;
    @(negedge clk);
    dif.in_pixel = '{x: 16'(x), y: 16'(y), depth: d, color: 12'(c), compare_depth: cmp};
    dif.in_valid = 1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (dif.in_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout x=%0d y=%0d", x, y);
      dif.in_valid = 0;
      return;
    end
    rng = (x < WIDTH) && (y < HEIGHT);
    a   = y * WIDTH + x;
    chk("depth_rd_en", longint'(dif.depth_rd_en), longint'(rng));
    if (!rng) exp_rej++;
    else begin
      chk("depth_rd_addr", dif.depth_rd_addr, a);
      if (!cmp || d < ref_d[a]) begin
        ref_d[a] = d;
        sb.push_back('{addr: a, color: c & 12'hFFF, depth: d, acc: cyc, lat: lat});
        exp_wr++;
      end else exp_rej++;
    end
    @(posedge clk);
    #1 dif.in_valid = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d busy=%0d", sb.size(), busy);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    begin_frame = 1;
    @(posedge clk);
    #1 begin_frame = 0;
    exp_wr  = 0;
    exp_rej = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_written"}, pixels_written, exp_wr);
    chk({tag, "_rejected"}, pixels_rejected, exp_rej);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = int'($urandom_range(0, 40));
    mem[5]  = 32'h0001_0000;
    mem[10] = 32'h7FFF_FFFF;
    for (int i = 0; i < NPIX; i++) ref_d[i] = mem[i];
    dif.in_valid = 0;
    dif.in_pixel = '0;
    dif.fb_ready = 0;

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_fb_valid", dif.fb_valid, 0);
    chk("rst_depth_wr_en", dif.depth_wr_en, 0);
    chk("rst_depth_rd_en", dif.depth_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", dif.in_ready, 1);
    chk_counts("rst");

    // Screen fill, fb always ready: latency A+2, one per cycle.
    dif.fb_ready = 1;
    for (int i = 0; i < 4; i++) send(i, 0, 100 + i, 16'h0A0 + i, 0, 1);
    drain();
    chk_counts("fill");

    // Depth test against memory value 1.0.
    frame_start();
    send(5, 0, 32'h0000_8000, 12'h111, 1, 1);
    send(5, 0, 32'h0002_0000, 12'h222, 1, 0);
    drain();
    chk_counts("ztest");

    // Back-to-back same address exercises forwarding.
    frame_start();
    send(10, 0, 10, 12'h301, 1, 1);
    send(10, 0, 20, 12'h302, 1, 1);
    send(10, 0, 5,  12'h303, 1, 1);
    drain();
    chk_counts("fwd");

    // Backpressure: S1 and S2 fill, third pixel waits.
    @(negedge clk);
    dif.fb_ready = 0;
    send(7, 1, 1, 12'h401, 0, 0);
    send(6, 1, 2, 12'h402, 0, 0);
    chk("in_ready_when_full", dif.in_ready, 0);
    fork
      send(5, 1, 3, 12'h403, 0, 0);
      begin repeat (5) @(negedge clk); dif.fb_ready = 1; end
    join
    drain();

    // Clipping.
    frame_start();
    send(WIDTH, 0, 0, 12'h500, 0, 0);
    send(0, HEIGHT, 0, 12'h501, 0, 0);
    drain();
    chk_counts("clip");

    // Random traffic with random backpressure and idle gaps.
    fbr_rand = 1;
    for (int n = 0; n < 300; n++) begin
      int x, y, d;
      x = int'($urandom_range(0, 15));
      x = (x == 15) ? WIDTH + int'($urandom_range(0, 5)) : x % 8;
      y = ($urandom_range(0, 20) == 0) ? HEIGHT : int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 60)) - 10;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(x, y, d, int'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0, 0);
    end
    fbr_rand = 0;
    @(negedge clk);
    dif.fb_ready = 1;
    drain();
    chk_counts("random");

    // begin_frame in the same cycle as a framebuffer handshake.
    @(negedge clk);
    dif.fb_ready = 0;
    send(0, 0, 7, 12'h600, 0, 0);
    @(negedge clk);
    @(negedge clk);
    dif.fb_ready = 1;
    begin_frame  = 1;
    @(posedge clk);
    #1 begin_frame = 0;
    exp_wr  = 1;
    exp_rej = 0;
    chk_counts("bf_collide");

    // Reset while stalled drops in-flight pixels immediately.
    @(negedge clk);
    dif.fb_ready = 0;
    send(1, 1, 0, 12'h700, 0, 0);
    send(2, 1, 0, 12'h701, 0, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rst_mid_fb_valid", dif.fb_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_en", dif.depth_wr_en, 0);
    sb.delete();
    exp_wr  = 0;
    exp_rej = 0;
    for (int i = 0; i < NPIX; i++) ref_d[i] = mem[i];
    @(negedge clk);
    rst = 0;
    dif.fb_ready = 1;
    #1;
    chk("post_rst_in_ready", dif.in_ready, 1);
    send(3, 1, 0, 12'h702, 0, 1);
    drain();
    chk_counts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/depth_writer.md
# depth_writer

Per-pixel depth-test and framebuffer write stage sitting directly downstream of the render manager. It consumes the manager's pixel stream (x, y, depth, color, compare flag) and runs a read-compare-write against an external depth-buffer BRAM. Winning pixels go to the framebuffer write port. The datapath is a two-stage pipeline with read-after-write forwarding, so it sustains one pixel per cycle when unstalled.

## Interface
- WIDTH, 320, screen width in pixels
- HEIGHT, 240, screen height in pixels
- ADDR_W, $clog2(WIDTH*HEIGHT), depth/framebuffer address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- begin_frame  in  1  single-cycle pulse; clears statistics counters
- in_pixel_x, in_pixel_y  in  16 each  pixel coordinates (unsigned)
- in_depth  in  q16_16_t  pixel depth (signed)
- in_color  in  color12_t  pixel color
- in_compare_depth  in  1  1: depth test; 0: unconditional write (screen fill)
- in_valid / in_ready  in / out  1  input handshake
- depth_rd_en, depth_rd_addr  out  1, ADDR_W  depth read request; data returns next cycle
- depth_rd_data  in  q16_16_t  read data; memory is read-first
- depth_wr_en, depth_wr_addr, depth_wr_data  out  1, ADDR_W, q16_16_t  depth write
- fb_valid / fb_ready  out / in  1  framebuffer write handshake
- fb_addr, fb_color  out  ADDR_W, color12_t  framebuffer write address/data
- pixels_written, pixels_rejected  out  32 each  statistics counters
- busy  out  1  any pipeline stage occupied

## Operation
- Address is y*WIDTH + x, computed combinationally on the input.
- Accept when in_valid && in_ready.
  - If x>=WIDTH or y>=HEIGHT: pixel is dropped at accept, pixels_rejected increments, no read is issued.
  - Otherwise, in the same cycle: depth_rd_en=1, depth_rd_addr=addr, and the pixel loads into S1.
- S1 captures depth_rd_data on its first cycle. If stalled, it keeps using the captured value; the memory port is not re-read.
- Effective stored depth, in priority order:
  - S2 occupied with the same address: S2 depth.
  - Last-write register (addr, depth, valid) matches: its depth.
  - Otherwise: captured memory data.
- Win condition: !compare_depth, or in_depth < stored (signed, strict). Equal depth loses.
- On S1 advance:
  - Winner moves into S2.
  - Loser is discarded and pixels_rejected increments.
- S2 drives fb_valid, fb_addr, fb_color.
- On fb_valid && fb_ready, in the same cycle:
  - depth_wr_en=1 with S2 addr/depth.
  - Last-write register updates.
  - pixels_written increments.
  - S2 frees.
- begin_frame clears both counters. An increment in the same cycle yields 1, not 0. The pipeline and last-write register are unaffected.
- Counters wrap at 2^32.

## Timing
- Reset values:
  - fb_valid=0, depth_wr_en=0, depth_rd_en=0, busy=0.
  - Counters=0, last-write valid=0, S1/S2 empty.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-operation discards in-flight pixels; no partial write is emitted.
- Latency: pixel accepted at cycle A appears on fb_valid at A+2.
- Throughput: 1 pixel/cycle while fb_ready=1.
- Stall logic:
  - S1 advance = S1 occupied && (!S2 occupied || fb_ready).
  - in_ready = !S1 occupied || S1 advance. This is combinational from fb_ready.
- fb_valid holds, and fb_addr/fb_color stay stable, until fb_ready.
- depth_wr_* is asserted only in the fb handshake cycle, never otherwise.
- busy = S1 occupied || S2 occupied.

## Structure
- q16_16_t and color12_t come from the shared renderer package.
- Add to that package:
  - the pixel_t struct (x, y, depth, color, compare_depth);
  - the FB_ADDR_W constant derived from WIDTH*HEIGHT.
- The address computation is a natural sub-module, pixel_addr_gen: combinational y*WIDTH + x plus the range check, reusable by the display scanout.
- The depth BRAM and framebuffer are external; not part of this block.

## Test plan
- Fill: stream 4 pixels with compare_depth=0 to (0,0)..(3,0), fb_ready=1.
  - fb writes at addr 0..3 on cycles A+2..A+5.
  - pixels_written=4.
- Depth test: memory holds 0x0001_0000 at addr 5 (x=5,y=0).
  - Pixel depth 0x0000_8000 is written.
  - Pixel depth 0x0002_0000 is rejected: pixels_rejected=1, no fb_valid.
- Back-to-back same address, memory holding 0x7FFF_FFFF, depths 10 then 20 then 5.
  - The 20 loses via S2/last-write forwarding.
  - The 5 is written.
  - Final depth_wr_data=5.
- Backpressure: hold fb_ready=0 for 5 cycles with 3 pixels queued.
  - in_ready drops once S1 and S2 are full.
  - fb_addr stays stable; no pixel is lost or duplicated.
- Clip: pixel (320,0) and pixel (0,240).
  - No depth_rd_en, no fb_valid.
  - pixels_rejected=2.
- begin_frame coinciding with an fb handshake: pixels_written=1 afterwards; asserting rst mid-stall gives fb_valid=0 and busy=0 immediately.
